// File: rtl/aud_pkg.sv
// Shared types and constants for the voice-recorder mode controller.
package aud_pkg;

  localparam int ADDR_W = 20;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_REC        = 3'd2,
    ST_REC_PAUSE  = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } aud_state_e;

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic dsp_start;
    logic dsp_pause;
    logic dsp_stop;
  } aud_pulse_t;

endpackage

// File: rtl/aud_mode_ctrl_if.sv
// Key/switch inputs and recorder/DSP control outputs of the mode controller.
interface aud_mode_ctrl_if;
  import aud_pkg::*;

  logic              i_init_done;
  logic              i_key_start;
  logic              i_key_pause;
  logic              i_key_stop;
  logic              i_mode_rec;
  logic [2:0]        i_speed_sw;
  logic              i_fast_sw;
  logic              i_interp_sw;
  logic              i_reverse_sw;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_full;
  logic              i_play_finish;

  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_dsp_start;
  logic              o_dsp_pause;
  logic              o_dsp_stop;
  logic [2:0]        o_dsp_speed;
  logic              o_dsp_fast;
  logic              o_dsp_slow_0;
  logic              o_dsp_slow_1;
  logic              o_dsp_reverse;
  logic [ADDR_W-1:0] o_sram_stop;
  logic              o_sram_we;
  logic [2:0]        o_state;
  logic [5:0]        o_seconds;

  modport master (
    input  i_init_done, i_key_start, i_key_pause, i_key_stop, i_mode_rec,
           i_speed_sw, i_fast_sw, i_interp_sw, i_reverse_sw,
           i_rec_addr, i_rec_full, i_play_finish,
    output o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop,
           o_dsp_speed, o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1, o_dsp_reverse,
           o_sram_stop, o_sram_we, o_state, o_seconds
  );

  modport slave (
    output i_init_done, i_key_start, i_key_pause, i_key_stop, i_mode_rec,
           i_speed_sw, i_fast_sw, i_interp_sw, i_reverse_sw,
           i_rec_addr, i_rec_full, i_play_finish,
    input  o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop,
           o_dsp_speed, o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1, o_dsp_reverse,
           o_sram_stop, o_sram_we, o_state, o_seconds
  );

endinterface

// File: rtl/sec_timer.sv
// Elapsed-seconds counter: tick prescaler plus a 6-bit seconds count saturating at 63.
module sec_timer #(
  parameter int TICKS_PER_SEC = 12000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_clr_all,
  input  logic       i_clr_tick,
  output logic [5:0] o_seconds
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    sec_q, sec_d;

  always_comb begin
    tick_d = tick_q;
    sec_d  = sec_q;
    if (i_clr_all) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (i_clr_tick) begin
      tick_d = '0;
    end else if (i_en) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (sec_q != 6'd63) sec_d = sec_q + 6'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else begin
      tick_q <= tick_d;
      sec_q  <= sec_d;
    end
  end

  assign o_seconds = sec_q;

endmodule

// File: rtl/aud_mode_ctrl.sv
// Record/play mode controller: key pulses to recorder/DSP control pulses,
// DSP config latch, recording end address and elapsed-seconds display.
module aud_mode_ctrl
  import aud_pkg::*;
#(
  parameter int TICKS_PER_SEC = 12000000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  aud_mode_ctrl_if.master bus
);

  aud_state_e        state_q, state_d;
  aud_pulse_t        pulse_q, pulse_d;
  logic              cfg_ld, sram_ld;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_stop_q;
  logic [2:0]        speed_q;
  logic              fast_q, slow0_q, slow1_q, reverse_q;
  logic              key_start, key_pause, key_stop;
  logic              tmr_en, tmr_clr_all, tmr_clr_tick;

  // stop > pause > start; only the winner is visible to the FSM
  assign key_stop  = bus.i_key_stop;
  assign key_pause = bus.i_key_pause & ~bus.i_key_stop;
  assign key_start = bus.i_key_start & ~bus.i_key_pause & ~bus.i_key_stop;

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    cfg_ld  = 1'b0;
    sram_ld = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (bus.i_init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (key_start) begin
          if (bus.i_mode_rec) begin
            state_d           = ST_REC;
            pulse_d.rec_start = 1'b1;
          end else if (sram_stop_q != '0) begin
            state_d           = ST_PLAY;
            pulse_d.dsp_start = 1'b1;
            cfg_ld            = 1'b1;
          end
        end
      end
      ST_REC: begin
        if (key_stop || bus.i_rec_full) begin
          state_d          = ST_IDLE;
          pulse_d.rec_stop = 1'b1;
          sram_ld          = 1'b1;
        end else if (key_pause) begin
          state_d           = ST_REC_PAUSE;
          pulse_d.rec_pause = 1'b1;
        end
      end
      ST_REC_PAUSE: begin
        if (key_stop) begin
          state_d          = ST_IDLE;
          pulse_d.rec_stop = 1'b1;
          sram_ld          = 1'b1;
        end else if (key_start) begin
          state_d           = ST_REC;
          pulse_d.rec_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (key_stop || bus.i_play_finish) begin
          state_d          = ST_IDLE;
          pulse_d.dsp_stop = 1'b1;
        end else if (key_pause) begin
          state_d           = ST_PLAY_PAUSE;
          pulse_d.dsp_pause = 1'b1;
        end
      end
      ST_PLAY_PAUSE: begin
        if (key_stop) begin
          state_d          = ST_IDLE;
          pulse_d.dsp_stop = 1'b1;
        end else if (key_start) begin
          state_d           = ST_PLAY;
          pulse_d.dsp_start = 1'b1;
          cfg_ld            = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      pulse_q     <= '0;
      sram_we_q   <= 1'b0;
      sram_stop_q <= '0;
      speed_q     <= '0;
      fast_q      <= 1'b0;
      slow0_q     <= 1'b0;
      slow1_q     <= 1'b0;
      reverse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      sram_we_q <= (state_d == ST_REC);
      if (sram_ld) sram_stop_q <= bus.i_rec_addr;
      if (cfg_ld) begin
        speed_q   <= bus.i_speed_sw;
        fast_q    <= bus.i_fast_sw;
        slow1_q   <= ~bus.i_fast_sw & bus.i_interp_sw;
        slow0_q   <= ~bus.i_fast_sw & ~bus.i_interp_sw;
        reverse_q <= bus.i_reverse_sw;
      end
    end
  end

  // Seconds restart only on a fresh start from IDLE; resume from pause keeps counting.
  assign tmr_en       = (state_q == ST_REC) || (state_q == ST_PLAY);
  assign tmr_clr_all  = (state_q == ST_IDLE) && (pulse_d.rec_start || pulse_d.dsp_start);
  assign tmr_clr_tick = (state_d == ST_IDLE) && (state_q != ST_IDLE);

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (tmr_en),
    .i_clr_all  (tmr_clr_all),
    .i_clr_tick (tmr_clr_tick),
    .o_seconds  (bus.o_seconds)
  );

  assign bus.o_rec_start   = pulse_q.rec_start;
  assign bus.o_rec_pause   = pulse_q.rec_pause;
  assign bus.o_rec_stop    = pulse_q.rec_stop;
  assign bus.o_dsp_start   = pulse_q.dsp_start;
  assign bus.o_dsp_pause   = pulse_q.dsp_pause;
  assign bus.o_dsp_stop    = pulse_q.dsp_stop;
  assign bus.o_dsp_speed   = speed_q;
  assign bus.o_dsp_fast    = fast_q;
  assign bus.o_dsp_slow_0  = slow0_q;
  assign bus.o_dsp_slow_1  = slow1_q;
  assign bus.o_dsp_reverse = reverse_q;
  assign bus.o_sram_stop   = sram_stop_q;
  assign bus.o_sram_we     = sram_we_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed bench for aud_mode_ctrl with a 4-tick second.
module tb_aud_mode_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  aud_mode_ctrl_if bus_if ();

  aud_mode_ctrl #(
    .TICKS_PER_SEC(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // keys = {start, pause, stop}, held for exactly one sampling edge
  task automatic keys(input logic [2:0] k);
    bus_if.i_key_start = k[2];
    bus_if.i_key_pause = k[1];
    bus_if.i_key_stop  = k[0];
    step();
    bus_if.i_key_start = 1'b0;
    bus_if.i_key_pause = 1'b0;
    bus_if.i_key_stop  = 1'b0;
  endtask

  function automatic logic [31:0] pulses();
    return 32'({bus_if.o_rec_start, bus_if.o_rec_pause, bus_if.o_rec_stop,
                bus_if.o_dsp_start, bus_if.o_dsp_pause, bus_if.o_dsp_stop});
  endfunction

  function automatic logic [31:0] flags();
    return 32'({bus_if.o_sram_we, bus_if.o_dsp_fast, bus_if.o_dsp_slow_0,
                bus_if.o_dsp_slow_1, bus_if.o_dsp_reverse, bus_if.o_dsp_speed});
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus_if.i_init_done   = 1'b0;
    bus_if.i_key_start   = 1'b0;
    bus_if.i_key_pause   = 1'b0;
    bus_if.i_key_stop    = 1'b0;
    bus_if.i_mode_rec    = 1'b0;
    bus_if.i_speed_sw    = 3'd0;
    bus_if.i_fast_sw     = 1'b0;
    bus_if.i_interp_sw   = 1'b0;
    bus_if.i_reverse_sw  = 1'b0;
    bus_if.i_rec_addr    = 20'h0;
    bus_if.i_rec_full    = 1'b0;
    bus_if.i_play_finish = 1'b0;
    repeat (3) step();

    chk("rst_state", 32'(bus_if.o_state), 0);
    chk("rst_pulses", pulses(), 0);
    chk("rst_flags", flags(), 0);
    chk("rst_sram_stop", 32'(bus_if.o_sram_stop), 0);
    chk("rst_seconds", 32'(bus_if.o_seconds), 0);

    // INIT holds and ignores keys until init_done
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      keys(3'b100);
      chk("init_state", 32'(bus_if.o_state), 0);
      chk("init_pulses", pulses(), 0);
    end
    bus_if.i_init_done = 1'b1;
    step();
    chk("init_to_idle", 32'(bus_if.o_state), 1);
    bus_if.i_init_done = 1'b0;
    step();
    chk("init_done_fall", 32'(bus_if.o_state), 1);

    // play request with nothing recorded is ignored
    keys(3'b100);
    chk("play_empty_pulses", pulses(), 0);
    chk("play_empty_state", 32'(bus_if.o_state), 1);

    // record, 20 cycles of REC = 5 seconds
    bus_if.i_mode_rec = 1'b1;
    keys(3'b100);
    chk("rec_start_pulse", pulses(), 32'b100000);
    chk("rec_state", 32'(bus_if.o_state), 2);
    chk("rec_we", 32'(bus_if.o_sram_we), 1);
    chk("rec_sec_clr", 32'(bus_if.o_seconds), 0);
    step();
    chk("rec_start_width", pulses(), 0);
    repeat (19) step();
    chk("rec_sec5", 32'(bus_if.o_seconds), 5);

    keys(3'b010);
    chk("rec_pause_pulse", pulses(), 32'b010000);
    chk("rec_pause_state", 32'(bus_if.o_state), 3);
    chk("rec_pause_we", 32'(bus_if.o_sram_we), 0);
    repeat (40) step();
    chk("rec_pause_hold", 32'(bus_if.o_seconds), 5);

    keys(3'b100);
    chk("rec_resume_pulse", pulses(), 32'b100000);
    chk("rec_resume_sec", 32'(bus_if.o_seconds), 5);
    bus_if.i_mode_rec = 1'b0;
    repeat (300) step();
    chk("rec_sec_sat", 32'(bus_if.o_seconds), 63);
    chk("rec_mode_ignored", 32'(bus_if.o_state), 2);

    bus_if.i_rec_addr = 20'h01234;
    keys(3'b001);
    chk("rec_stop_pulse", pulses(), 32'b001000);
    chk("rec_stop_addr", 32'(bus_if.o_sram_stop), 32'h01234);
    chk("rec_stop_state", 32'(bus_if.o_state), 1);
    chk("rec_stop_we", 32'(bus_if.o_sram_we), 0);
    chk("rec_stop_sec", 32'(bus_if.o_seconds), 63);
    bus_if.i_rec_addr = 20'h0ffff;
    step();
    chk("rec_stop_width", pulses(), 0);
    chk("sram_stop_hold", 32'(bus_if.o_sram_stop), 32'h01234);

    // play: slow, interpolated, reversed at speed 3
    bus_if.i_speed_sw   = 3'd3;
    bus_if.i_fast_sw    = 1'b0;
    bus_if.i_interp_sw  = 1'b1;
    bus_if.i_reverse_sw = 1'b1;
    keys(3'b100);
    chk("play_start_pulse", pulses(), 32'b000100);
    chk("play_state", 32'(bus_if.o_state), 4);
    // {we, fast, slow_0, slow_1, reverse, speed}
    chk("play_cfg", flags(), 32'b0_0_0_1_1_011);
    chk("play_sec_clr", 32'(bus_if.o_seconds), 0);
    bus_if.i_speed_sw = 3'd5;
    bus_if.i_interp_sw = 1'b0;
    bus_if.i_rec_full = 1'b1;
    repeat (8) step();
    bus_if.i_rec_full = 1'b0;
    chk("play_cfg_stable", flags(), 32'b0_0_0_1_1_011);
    chk("play_rec_full_ign", 32'(bus_if.o_state), 4);
    chk("play_sec2", 32'(bus_if.o_seconds), 2);

    bus_if.i_play_finish = 1'b1;
    step();
    bus_if.i_play_finish = 1'b0;
    chk("finish_pulse", pulses(), 32'b000001);
    chk("finish_state", 32'(bus_if.o_state), 1);
    chk("finish_sec_hold", 32'(bus_if.o_seconds), 2);
    step();
    chk("finish_width", pulses(), 0);
    bus_if.i_play_finish = 1'b1;
    step();
    bus_if.i_play_finish = 1'b0;
    chk("finish_idle_ign", pulses(), 0);

    // fast play, pause, re-latch on resume, then all keys together
    bus_if.i_speed_sw   = 3'd7;
    bus_if.i_fast_sw    = 1'b1;
    bus_if.i_reverse_sw = 1'b0;
    keys(3'b100);
    chk("fast_cfg", flags(), 32'b0_1_0_0_0_111);
    keys(3'b010);
    chk("play_pause_pulse", pulses(), 32'b000010);
    chk("play_pause_state", 32'(bus_if.o_state), 5);
    bus_if.i_speed_sw   = 3'd2;
    bus_if.i_fast_sw    = 1'b0;
    bus_if.i_interp_sw  = 1'b0;
    bus_if.i_reverse_sw = 1'b1;
    step();
    chk("pause_cfg_hold", flags(), 32'b0_1_0_0_0_111);
    keys(3'b100);
    chk("resume_pulse", pulses(), 32'b000100);
    chk("resume_cfg", flags(), 32'b0_0_1_0_1_010);
    keys(3'b111);
    chk("all_keys_pulse", pulses(), 32'b000001);
    chk("all_keys_state", 32'(bus_if.o_state), 1);

    // start+pause in REC: pause wins; stop from REC_PAUSE latches address
    bus_if.i_mode_rec = 1'b1;
    keys(3'b100);
    chk("rec2_state", 32'(bus_if.o_state), 2);
    keys(3'b110);
    chk("rec2_pause_wins", pulses(), 32'b010000);
    chk("rec2_pause_state", 32'(bus_if.o_state), 3);
    bus_if.i_rec_addr = 20'h00abc;
    keys(3'b001);
    chk("rec2_stop_pulse", pulses(), 32'b001000);
    chk("rec2_stop_addr", 32'(bus_if.o_sram_stop), 32'h00abc);

    // rec_full ends a recording
    keys(3'b100);
    bus_if.i_rec_addr = 20'hfffff;
    bus_if.i_rec_full = 1'b1;
    step();
    bus_if.i_rec_full = 1'b0;
    chk("rec_full_pulse", pulses(), 32'b001000);
    chk("rec_full_addr", 32'(bus_if.o_sram_stop), 32'hfffff);

    // asynchronous reset mid-recording
    keys(3'b100);
    chk("rec3_state", 32'(bus_if.o_state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus_if.o_state), 0);
    chk("async_rst_pulses", pulses(), 0);
    chk("async_rst_flags", flags(), 0);
    chk("async_rst_sram", 32'(bus_if.o_sram_stop), 0);
    step();
    chk("async_rst_sec", 32'(bus_if.o_seconds), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aud_mode_ctrl.md
# aud_mode_ctrl

Top-level mode controller for the voice recorder. It turns debounced key pulses and configuration switches into start/pause/stop pulses for the recorder and the playback DSP, and latches the DSP speed configuration. It records the end address of the last recording so playback knows where to stop, and keeps an elapsed-seconds counter for the display. It sits between the key debouncers and the recorder/DSP pair, after codec initialisation.

## Interface
- TICKS_PER_SEC, default 12000000: `i_clk` cycles per elapsed second.
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock, asynchronous active-low reset
- i_init_done  in  1  codec initialisation complete (level)
- i_key_start / i_key_pause / i_key_stop  in  1 each  one-cycle debounced key pulses
- i_mode_rec  in  1  switch: 1 = record, 0 = play
- i_speed_sw  in  3  speed factor, 0..7
- i_fast_sw  in  1  1 = fast play, 0 = slow play
- i_interp_sw  in  1  slow mode: 1 = linear interpolation, 0 = sample hold
- i_reverse_sw  in  1  reverse playback
- i_rec_addr  in  20  recorder's current write address
- i_rec_full  in  1  recorder reached the top of the SRAM
- i_play_finish  in  1  DSP reached its end address
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle pulses to the recorder
- o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  one-cycle pulses to the DSP
- o_dsp_speed  out  3  latched speed
- o_dsp_fast  out  1  latched fast flag
- o_dsp_slow_0 / o_dsp_slow_1  out  1 each  latched slow-mode select: slow_0 = sample hold, slow_1 = linear interpolation
- o_dsp_reverse  out  1  latched reverse flag
- o_sram_stop  out  20  end address of the last recording
- o_sram_we  out  1  1 while the recorder owns the SRAM (state REC)
- o_state  out  3  current state encoding, for display
- o_seconds  out  6  elapsed seconds

## Operation
- States: INIT=0, IDLE=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5.
- Key priority when keys coincide: stop > pause > start. Only the winning key acts.
- INIT:
  - Stays in INIT until `i_init_done`=1, then goes to IDLE.
  - All keys are ignored in INIT.
- IDLE:
  - start with `i_mode_rec`=1 → REC, pulse `o_rec_start`, clear the seconds counter.
  - start with `i_mode_rec`=0 and `o_sram_stop`≠0 → PLAY, pulse `o_dsp_start`, latch the configuration (see below), clear the seconds counter.
  - start with `i_mode_rec`=0 and `o_sram_stop`=0 is ignored; the state stays IDLE.
- Configuration latch, loaded with every `o_dsp_start`:
  - speed = `i_speed_sw`, fast = `i_fast_sw`, reverse = `i_reverse_sw`.
  - slow_1 = `~i_fast_sw & i_interp_sw`.
  - slow_0 = `~i_fast_sw & ~i_interp_sw`.
  - Switch changes at any other time have no effect.
- REC:
  - pause → REC_PAUSE, pulse `o_rec_pause`.
  - stop or `i_rec_full` → IDLE, pulse `o_rec_stop`, `o_sram_stop` ← `i_rec_addr`.
- REC_PAUSE:
  - start → REC, pulse `o_rec_start`.
  - stop → IDLE, pulse `o_rec_stop`, latch `o_sram_stop`.
- PLAY:
  - pause → PLAY_PAUSE, pulse `o_dsp_pause`.
  - stop → IDLE, pulse `o_dsp_stop`.
  - `i_play_finish` → IDLE, pulse `o_dsp_stop` so the DSP address returns to 0.
- PLAY_PAUSE:
  - start → PLAY, pulse `o_dsp_start` and re-latch the configuration.
  - stop → IDLE, pulse `o_dsp_stop`.
- `i_mode_rec` is sampled only in IDLE; changing it mid-operation has no effect.
- `i_play_finish` and `i_rec_full` are ignored outside PLAY and REC respectively.
- Seconds counter:
  - A tick counter runs 0..TICKS_PER_SEC-1, only in REC and PLAY.
  - On wrap it increments `o_seconds`, which saturates at 63.
  - In the pause states both counters hold.
  - On entering IDLE the tick counter clears and `o_seconds` holds its final value.

## Timing
- All outputs are registered. A key pulse sampled at cycle N produces the state change and the output pulse at cycle N+1; every output pulse is exactly one cycle wide.
- The latched configuration is valid in the same cycle as `o_dsp_start` and stays stable until the next `o_dsp_start`.
- `o_sram_stop` updates in the same cycle as `o_rec_stop`. It is never cleared except by reset.
- Reset values:
  - State = INIT, `o_state` = 0.
  - All pulses, `o_sram_we`, and the latched flags = 0.
  - `o_dsp_speed` = 0, `o_sram_stop` = 0, `o_seconds` = 0, tick counter = 0.
- Reset asserted mid-operation returns to INIT immediately and asynchronously; no stop pulse is issued.
- `i_init_done` falling after INIT has no effect.

## Structure
- Shared package `aud_pkg`: state enum (3-bit, values above) and the `ADDR_W`=20 constant.
- One sub-module is natural: `sec_timer`, holding the tick counter and saturating seconds counter, with enable/clear inputs and TICKS_PER_SEC as a parameter.

## Test plan
- Reset with `i_init_done`=0 for 10 cycles, then raise it → `o_state`=0 until the cycle after the rise, then 1. All outputs 0 throughout.
- Set `i_mode_rec`=1, pulse start; then with `i_rec_addr`=0x01234, pulse stop → `o_rec_start` one cycle after start and `o_sram_we`=1 while in REC. On stop: `o_rec_stop` pulses, `o_sram_stop`=0x01234, `o_state`=1.
- After reset, with `i_mode_rec`=0 and `o_sram_stop`=0, pulse start → no `o_dsp_start`, state stays IDLE.
- In the play setup (recording done, `i_mode_rec`=0):
  - Set speed=3, fast=0, interp=1, pulse start → `o_dsp_speed`=3, `o_dsp_slow_1`=1, `o_dsp_slow_0`=0.
  - Change `i_speed_sw`=5 mid-play → `o_dsp_speed` stays 3.
  - Raise `i_play_finish` → `o_dsp_stop` pulse, state IDLE.
- Pulse start, pause and stop in the same cycle during PLAY → only `o_dsp_stop` pulses, state IDLE.
- With TICKS_PER_SEC=4:
  - Record for 20 cycles → `o_seconds`=5.
  - Pause for 40 cycles → `o_seconds` still 5.
  - Resume long enough to pass 63 s → `o_seconds` saturates at 63.
